// File: rtl/syscall_display.sv
// Syscall output stage for the single-cycle CPU: latches printed values, gates the CPU clock
// enable around prints and exit, and scans the held value onto an 8-digit hex display.
module syscall_display #(
   parameter int SCAN_DIV     = 50000,
   parameter bit PAUSE_ON_OUT = 1'b1
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        syscall_valid,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   input  logic        resume,
   output logic        cpu_en,
   output logic        halted,
   output logic [31:0] disp_val,
   output logic [15:0] print_cnt,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   typedef enum logic [1:0] {RUN, PAUSE, HALT} state_t;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   state_t      state_q, state_d;
   logic [31:0] disp_val_q, disp_val_d;
   logic [15:0] print_cnt_q, print_cnt_d;
   logic [15:0] div_cnt_q, div_cnt_d;
   logic [2:0]  digit_idx_q, digit_idx_d;
   logic        resume_q;
   logic        resume_rise;
   logic [3:0]  nibble;

   function automatic logic [6:0] hexToSeg(input logic [3:0] n);
      case (n)
         4'h0: hexToSeg = 7'h40;
         4'h1: hexToSeg = 7'h79;
         4'h2: hexToSeg = 7'h24;
         4'h3: hexToSeg = 7'h30;
         4'h4: hexToSeg = 7'h19;
         4'h5: hexToSeg = 7'h12;
         4'h6: hexToSeg = 7'h02;
         4'h7: hexToSeg = 7'h78;
         4'h8: hexToSeg = 7'h00;
         4'h9: hexToSeg = 7'h10;
         4'hA: hexToSeg = 7'h08;
         4'hB: hexToSeg = 7'h03;
         4'hC: hexToSeg = 7'h46;
         4'hD: hexToSeg = 7'h21;
         4'hE: hexToSeg = 7'h06;
         default: hexToSeg = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q     <= RUN;
         disp_val_q  <= 32'h0;
         print_cnt_q <= 16'h0;
         div_cnt_q   <= 16'h0;
         digit_idx_q <= 3'd0;
         resume_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         disp_val_q  <= disp_val_d;
         print_cnt_q <= print_cnt_d;
         div_cnt_q   <= div_cnt_d;
         digit_idx_q <= digit_idx_d;
         resume_q    <= resume;
      end
   end

   // Only a fresh low-to-high on the button counts, so a held button resumes once.
   assign resume_rise = resume & ~resume_q;

   always_comb begin
      state_d     = state_q;
      disp_val_d  = disp_val_q;
      print_cnt_d = print_cnt_q;
      case (state_q)
         RUN: begin
            if (syscall_valid) begin
               if (v0 == 32'ha) begin
                  state_d = HALT;
               end else begin
                  disp_val_d  = a0;
                  print_cnt_d = print_cnt_q + 16'd1;
                  if (PAUSE_ON_OUT) state_d = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (resume_rise) state_d = RUN;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Digit scan runs in every state so the display stays alive while paused or halted.
   always_comb begin
      div_cnt_d   = div_cnt_q + 16'd1;
      digit_idx_d = digit_idx_q;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d   = 16'h0;
         digit_idx_d = digit_idx_q + 3'd1;
      end
   end

   assign nibble    = disp_val_q[{digit_idx_q, 2'b00} +: 4];
   assign cpu_en    = (state_q == RUN);
   assign halted    = (state_q == HALT);
   assign disp_val  = disp_val_q;
   assign print_cnt = print_cnt_q;
   assign an        = ~(8'b1 << digit_idx_q);
   assign seg       = {~((state_q == HALT) && (digit_idx_q == 3'd0)), hexToSeg(nibble)};

endmodule

// File: tb/tb_syscall_display.sv
// Self-checking bench for syscall_display: directed and random syscall/resume traffic
// compared each cycle against a behavioural model of the print/pause/exit rules.
module tb_syscall_display;

   logic        clk = 1'b0;
   logic        rstA, rstB;
   logic        svA, resA, svB, resB;
   logic [31:0] v0A, a0A, v0B, a0B;
   logic        cpuEnA, haltedA, cpuEnB, haltedB;
   logic [31:0] dispA, dispB;
   logic [15:0] cntA, cntB;
   logic [7:0]  anA, segA, anB, segB;

   int checks = 0;
   int errors = 0;

   // Model of instance A: 0 = running, 1 = paused, 2 = halted.
   int          mdlState;
   logic [31:0] mdlDisp;
   logic [15:0] mdlCnt;
   logic        mdlPrev;
   int          mdlCycles;

   logic [7:0] hexTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   always #5 clk = ~clk;

   syscall_display #(.SCAN_DIV(4), .PAUSE_ON_OUT(1'b1)) dutA (
      .clk(clk), .RST(rstA), .syscall_valid(svA), .v0(v0A), .a0(a0A), .resume(resA),
      .cpu_en(cpuEnA), .halted(haltedA), .disp_val(dispA), .print_cnt(cntA),
      .an(anA), .seg(segA)
   );

   syscall_display #(.SCAN_DIV(1), .PAUSE_ON_OUT(1'b0)) dutB (
      .clk(clk), .RST(rstB), .syscall_valid(svB), .v0(v0B), .a0(a0B), .resume(resB),
      .cpu_en(cpuEnB), .halted(haltedB), .disp_val(dispB), .print_cnt(cntB),
      .an(anB), .seg(segB)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mdlState  = 0;
      mdlDisp   = 32'h0;
      mdlCnt    = 16'h0;
      mdlPrev   = 1'b0;
      mdlCycles = 0;
   endtask

   task automatic checkOutput(input string tag);
      int         digit;
      logic [3:0] nib;
      logic [7:0] glyph;
      logic [7:0] expAn;
      digit = (mdlCycles / 4) % 8;
      nib   = 4'((mdlDisp >> (4 * digit)) & 32'hF);
      glyph = hexTable[nib];
      expAn = ~(8'd1 << digit);
      check({tag, ".cpu_en"}, 32'(cpuEnA), 32'(mdlState == 0));
      check({tag, ".halted"}, 32'(haltedA), 32'(mdlState == 2));
      check({tag, ".disp"}, dispA, mdlDisp);
      check({tag, ".cnt"}, 32'(cntA), 32'(mdlCnt));
      check({tag, ".an"}, 32'(anA), 32'(expAn));
      check({tag, ".seg"}, 32'(segA), 32'({~(mdlState == 2 && digit == 0), glyph[6:0]}));
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, ".cpu_en"}, 32'(cpuEnA), 32'd1);
      check({tag, ".halted"}, 32'(haltedA), 32'd0);
      check({tag, ".disp"}, dispA, 32'h0);
      check({tag, ".cnt"}, 32'(cntA), 32'h0);
      check({tag, ".an"}, 32'(anA), 32'hFE);
      check({tag, ".seg"}, 32'(segA), 32'hC0);
   endtask

   task automatic applyStimulus(input string tag, input logic sv, input logic [31:0] v,
                                input logic [31:0] a, input logic res);
      svA = sv; v0A = v; a0A = a; resA = res;
      @(posedge clk);
      #1;
      if (mdlState == 0 && sv) begin
         if (v == 32'ha) mdlState = 2;
         else begin
            mdlDisp  = a;
            mdlCnt   = mdlCnt + 16'd1;
            mdlState = 1;
         end
      end else if (mdlState == 1 && res && !mdlPrev) begin
         mdlState = 0;
      end
      mdlPrev = res;
      mdlCycles++;
      checkOutput(tag);
   endtask

   // Drops reset mid-cycle, checks outputs before and after a clock edge, releases mid-cycle.
   task automatic asyncReset(input string tag);
      #2 rstA = 1'b0;
      #1 checkResetValues({tag, ".async"});
      svA = 1'b0; resA = 1'b0;
      modelReset();
      @(posedge clk);
      #1 checkResetValues({tag, ".held"});
      #2 rstA = 1'b1;
   endtask

   initial begin
      logic [31:0] rv;
      rstA = 1'b1; rstB = 1'b1;
      svA = 1'b0; v0A = 32'h0; a0A = 32'h0; resA = 1'b0;
      svB = 1'b0; v0B = 32'h0; a0B = 32'h0; resB = 1'b0;
      #2 rstA = 1'b0; rstB = 1'b0;
      #1 checkResetValues("reset");
      modelReset();
      #4 rstA = 1'b1; rstB = 1'b1;

      $display("[TB] idle scan");
      for (int i = 0; i < 36; i++) applyStimulus("idle", 1'b0, 32'h0, 32'h0, 1'b0);

      $display("[TB] print and paused scan");
      applyStimulus("print", 1'b1, 32'd1, 32'h1234ABCD, 1'b0);
      for (int i = 0; i < 32; i++) applyStimulus("paused", 1'b1, 32'd1, 32'hFFFF0000, 1'b0);

      $display("[TB] held resume");
      for (int i = 0; i < 10; i++) applyStimulus("resumeHeld", 1'b1, 32'd4, $urandom, 1'b1);
      applyStimulus("resumeLow", 1'b0, 32'd0, 32'h0, 1'b0);
      applyStimulus("resumeRise", 1'b0, 32'd0, 32'h0, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         rv = 32'($urandom_range(0, 15));
         if (rv == 32'ha) rv = 32'd1;
         applyStimulus("random", ($urandom_range(0, 2) == 0), rv, $urandom,
                       1'($urandom_range(0, 1)));
      end

      $display("[TB] pause then async reset");
      applyStimulus("prePause", 1'b0, 32'd0, 32'h0, 1'b0);
      applyStimulus("pauseRst", 1'b1, 32'd1, 32'hCAFE0001, 1'b0);
      asyncReset("midPause");
      for (int i = 0; i < 8; i++) applyStimulus("afterRst1", 1'b0, 32'd0, 32'h0, 1'b0);

      $display("[TB] exit");
      applyStimulus("print5", 1'b1, 32'd1, 32'd5, 1'b0);
      applyStimulus("rise5", 1'b0, 32'd0, 32'h0, 1'b1);
      applyStimulus("exit", 1'b1, 32'ha, 32'h77, 1'b0);
      for (int i = 0; i < 40; i++)
         applyStimulus("halted", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                       $urandom, 1'($urandom_range(0, 1)));
      asyncReset("inHalt");
      for (int i = 0; i < 4; i++) applyStimulus("afterRst2", 1'b0, 32'd0, 32'h0, 1'b0);
      applyStimulus("runAgain", 1'b1, 32'd1, 32'h89ABCDEF, 1'b0);

      $display("[TB] print counter wrap without pausing");
      svB = 1'b1; v0B = 32'd1;
      for (int i = 1; i <= 65535; i++) begin
         a0B = 32'(i);
         @(posedge clk);
         #1 check("noPause.cpu_en", 32'(cpuEnB), 32'd1);
      end
      check("wrap.preCnt", 32'(cntB), 32'hFFFF);
      check("wrap.preDisp", dispB, 32'd65535);
      a0B = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      check("wrap.cnt", 32'(cntB), 32'h0000);
      check("wrap.cpu_en", 32'(cpuEnB), 32'd1);
      check("wrap.disp", dispB, 32'hDEADBEEF);
      svB = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
